// File: rtl/median_pkg.sv
// Shared constants for the median-filter frame sequencer: frame geometry defaults,
// address width and the FSM state encoding.
package median_pkg;

    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int ADDR_W    = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ARM   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

endpackage

// File: rtl/raster_addr_ctr.sv
// Raster-order x/y address counter: x runs fastest and wraps into y.
// 'last' flags the final pixel of the frame.
module raster_addr_ctr
    import median_pkg::*;
#(
    parameter int W = DEF_IMG_W,
    parameter int H = DEF_IMG_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    output logic [ADDR_W-1:0] x,
    output logic [ADDR_W-1:0] y,
    output logic              last
);

    logic [ADDR_W-1:0] xReg;
    logic [ADDR_W-1:0] yReg;
    logic              xWrap;
    logic              yWrap;

    assign xWrap = (xReg == ADDR_W'(W - 1));
    assign yWrap = (yReg == ADDR_W'(H - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            xReg <= '0;
            yReg <= '0;
        end else if (en) begin
            if (xWrap) begin
                xReg <= '0;
                yReg <= yWrap ? '0 : yReg + 1'b1;
            end else begin
                xReg <= xReg + 1'b1;
            end
        end
    end

    assign x    = xReg;
    assign y    = yReg;
    assign last = xWrap && yWrap;

endmodule

// File: rtl/median_frame_sequencer.sv
// Frame controller for the binary median engine: loads the image RAM, runs the engine
// under a watchdog, then streams the result RAM out through a 2-entry FIFO.
module median_frame_sequencer
    import median_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int WDOG_MAX = 2**20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameReq,
    output logic              frameAck,
    input  logic              pixValid,
    input  logic              pixData,
    output logic              pixReady,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramX,
    output logic [ADDR_W-1:0] ramY,
    output logic              ramWrData,
    input  logic [ADDR_W-1:0] engX,
    input  logic [ADDR_W-1:0] engY,
    output logic              engReset,
    output logic              engStart,
    input  logic              engDone,
    output logic [ADDR_W-1:0] resX,
    output logic [ADDR_W-1:0] resY,
    input  logic              resRamData,
    output logic              resValid,
    output logic              resData,
    input  logic              resReady,
    output logic              busy,
    output logic              frameDone,
    output logic              timeoutErr
);

    localparam int WDOG_W = $clog2(WDOG_MAX);

    logic [2:0]        stateReg, stateNext;
    logic [WDOG_W-1:0] wdogReg;
    logic              timeoutErrReg, engResetPulseReg, frameDoneReg;
    logic              accept, loadEn, wdogExpire;
    logic [ADDR_W-1:0] loadX, loadY, drainX, drainY;
    logic              loadLast, drainLast;

    logic       fifoMem [2];
    logic       fifoWrPtr, fifoRdPtr, inFlightReg, rdDoneReg;
    logic [1:0] fifoCount, occNet;
    logic       pop, rdIssue, lastPop;

    assign accept     = (stateReg == S_IDLE) && frameReq;
    assign loadEn     = (stateReg == S_LOAD) && pixValid;
    assign wdogExpire = (stateReg == S_RUN) && !engDone && (wdogReg == WDOG_W'(WDOG_MAX - 1));

    raster_addr_ctr #(.W(IMG_W), .H(IMG_H)) loadCtr (
        .clk(clk), .reset(reset), .clear(accept), .en(loadEn),
        .x(loadX), .y(loadY), .last(loadLast)
    );

    raster_addr_ctr #(.W(IMG_W), .H(IMG_H)) drainCtr (
        .clk(clk), .reset(reset), .clear(accept), .en(rdIssue),
        .x(drainX), .y(drainY), .last(drainLast)
    );

    // Occupancy net of this cycle's pop lets a read issue behind every pop,
    // so the stream sustains one pixel per cycle.
    assign pop     = resValid && resReady;
    assign occNet  = fifoCount - {1'b0, pop} + {1'b0, inFlightReg};
    assign rdIssue = (stateReg == S_DRAIN) && !rdDoneReg && (occNet < 2'd2);
    assign lastPop = pop && rdDoneReg && !inFlightReg && (fifoCount == 2'd1);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            S_IDLE:  if (frameReq) stateNext = S_LOAD;
            S_LOAD:  if (loadEn && loadLast) stateNext = S_ARM;
            S_ARM:   stateNext = S_RUN;
            S_RUN: begin
                if (engDone) stateNext = S_DRAIN;
                else if (wdogExpire) stateNext = S_IDLE;
            end
            S_DRAIN: if (lastPop) stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg         <= S_IDLE;
            wdogReg          <= '0;
            timeoutErrReg    <= 1'b0;
            engResetPulseReg <= 1'b0;
            frameDoneReg     <= 1'b0;
            fifoWrPtr        <= 1'b0;
            fifoRdPtr        <= 1'b0;
            fifoCount        <= '0;
            inFlightReg      <= 1'b0;
            rdDoneReg        <= 1'b0;
        end else begin
            stateReg         <= stateNext;
            engResetPulseReg <= wdogExpire;
            frameDoneReg     <= lastPop;
            inFlightReg      <= rdIssue;

            if (stateReg != S_RUN) wdogReg <= '0;
            else if (wdogReg != '1) wdogReg <= wdogReg + 1'b1;

            if (wdogExpire) timeoutErrReg <= 1'b1;
            else if (accept) timeoutErrReg <= 1'b0;

            if (accept) rdDoneReg <= 1'b0;
            else if (rdIssue && drainLast) rdDoneReg <= 1'b1;

            if (inFlightReg) fifoWrPtr <= ~fifoWrPtr;
            if (pop) fifoRdPtr <= ~fifoRdPtr;
            fifoCount <= fifoCount + {1'b0, inFlightReg} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (inFlightReg) fifoMem[fifoWrPtr] <= resRamData;
    end

    always_comb begin
        ramX = '0;
        ramY = '0;
        if (stateReg == S_LOAD) begin
            ramX = loadX;
            ramY = loadY;
        end else if (stateReg == S_RUN) begin
            ramX = engX;
            ramY = engY;
        end
    end

    assign frameAck   = accept;
    assign pixReady   = (stateReg == S_LOAD);
    assign ramWe      = loadEn;
    assign ramWrData  = loadEn && pixData;
    assign engReset   = (stateReg == S_ARM) || engResetPulseReg;
    assign engStart   = (stateReg == S_RUN);
    assign resX       = (stateReg == S_DRAIN) ? drainX : '0;
    assign resY       = (stateReg == S_DRAIN) ? drainY : '0;
    assign resValid   = (fifoCount != 2'd0);
    assign resData    = resValid && fifoMem[fifoRdPtr];
    assign busy       = (stateReg != S_IDLE);
    assign frameDone  = frameDoneReg;
    assign timeoutErr = timeoutErrReg;

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Scoreboard bench for median_frame_sequencer on a 4x4 frame with a 64-cycle watchdog.
module tb_median_frame_sequencer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WD = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frameReq = 1'b0, pixValid = 1'b0, pixData = 1'b0;
    logic       engDone = 1'b0, resRamData = 1'b0, resReady = 1'b1;
    logic [7:0] engX = '0, engY = '0;
    logic       frameAck, pixReady, ramWe, ramWrData, engReset, engStart;
    logic       resValid, resData, busy, frameDone, timeoutErr;
    logic [7:0] ramX, ramY, resX, resY;

    int tests = 0, fails = 0, cyc = 0;
    int beats = 0, firstPopCyc = 0, lastPopCyc = 0;
    logic [16:0] wrQ[$];
    logic        resQ[$];
    logic        resMem [16];
    logic [16:0] wrExp;
    logic        resExp;

    median_frame_sequencer #(.IMG_W(W), .IMG_H(H), .WDOG_MAX(WD)) dut (
        .clk(clk), .reset(reset), .frameReq(frameReq), .frameAck(frameAck),
        .pixValid(pixValid), .pixData(pixData), .pixReady(pixReady),
        .ramWe(ramWe), .ramX(ramX), .ramY(ramY), .ramWrData(ramWrData),
        .engX(engX), .engY(engY), .engReset(engReset), .engStart(engStart),
        .engDone(engDone), .resX(resX), .resY(resY), .resRamData(resRamData),
        .resValid(resValid), .resData(resData), .resReady(resReady),
        .busy(busy), .frameDone(frameDone), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Result RAM model: one-cycle registered read
    always @(posedge clk) resRamData <= resMem[{resY[1:0], resX[1:0]}];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop expected writes / result beats whenever the DUT presents them
    always @(negedge clk) begin
        if (!reset && ramWe) begin
            if (wrQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL ram_write_extra: got x=%0d y=%0d d=%0b expected no write", ramX, ramY, ramWrData);
            end else begin
                wrExp = wrQ.pop_front();
                check("ram_write", {15'd0, ramX, ramY, ramWrData}, {15'd0, wrExp});
                $display("[TB] write x=%0d y=%0d d=%0b", ramX, ramY, ramWrData);
            end
        end
        if (!reset && resValid && resReady) begin
            if (beats == 0) firstPopCyc = cyc;
            lastPopCyc = cyc;
            beats++;
            if (resQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL result_extra: got %0b expected no beat", resData);
            end else begin
                resExp = resQ.pop_front();
                check("result_beat", {31'd0, resData}, {31'd0, resExp});
                $display("[TB] result beat %0d d=%0b", beats, resData);
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_addr"}, {ramX, ramY, resX, resY}, 32'd0);
        check({name, "_flags"}, {21'd0, frameAck, pixReady, ramWe, ramWrData, engReset, engStart,
                                 resValid, resData, busy, frameDone, timeoutErr}, 32'd0);
    endtask

    task automatic request();
        frameReq = 1'b1;
        @(negedge clk);
        check("frame_ack", {30'd0, frameAck, busy}, 32'b10);
        tick();
        frameReq = 1'b0;
        @(negedge clk);
        check("after_ack", {30'd0, busy, timeoutErr}, 32'b10);
        tick();
    endtask

    // Loads a frame; returns in RUN cycle 1 (inputs phase)
    task automatic load(input logic [15:0] pix, input bit randomGaps);
        int sent = 0;
        int c = 0;
        bit v;
        while (sent < W * H) begin
            v = randomGaps ? ($urandom_range(0, 3) != 0) : ((c % 3) != 2);
            pixValid = v;
            if (v) begin
                pixData = pix[sent];
                wrQ.push_back({8'(sent % W), 8'(sent / W), pix[sent]});
                sent++;
            end else begin
                pixData = 1'($urandom);
            end
            c++;
            @(negedge clk);
            check("pix_ready", {31'd0, pixReady}, 32'd1);
            tick();
        end
        pixValid = 1'b0;
        @(negedge clk);
        check("arm_state", {29'd0, engReset, engStart, busy}, 32'b101);
        check("writes_consumed", wrQ.size(), 0);
        tick();
        engX = 8'd5;
        engY = 8'd7;
        @(negedge clk);
        check("run_ram_mux", {15'd0, ramX, ramY, ramWe}, {15'd0, 8'd5, 8'd7, 1'b0});
        check("run_state", {30'd0, engStart, engReset}, 32'b10);
        tick();
    endtask

    task automatic run_done(input int n);
        repeat (n - 2) tick();
        engDone = 1'b1;
        beats = 0;
        for (int i = 0; i < W * H; i++) resQ.push_back(resMem[i]);
        tick();
        engDone = 1'b0;
        @(negedge clk);
        check("drain_entry", {29'd0, engStart, engReset, busy}, 32'b001);
        tick();
    endtask

    task automatic drain(input bit toggle);
        int k = 0;
        int doneCyc = 0;
        bit seen = 0;
        while (k < 300 && !seen) begin
            resReady = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            @(negedge clk);
            if (frameDone) begin
                seen = 1;
                doneCyc = cyc;
                check("idle_at_done", {31'd0, busy}, 32'd0);
            end
            tick();
            k++;
        end
        resReady = 1'b1;
        if (!seen) begin
            tests++; fails++;
            $display("FAIL frame_done_wait: got no frameDone expected pulse within 300 cycles");
        end
        check("done_after_last_pop", doneCyc, lastPopCyc + 1);
        check("beat_count", beats, W * H);
        check("results_consumed", resQ.size(), 0);
        if (!toggle) check("beats_consecutive", lastPopCyc - firstPopCyc, W * H - 1);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        logic [15:0] rp;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");
        tick();

        // Frame A: gapped 0xA5C3 load, 40-cycle run, row-parity result, ready held high
        for (int i = 0; i < W * H; i++) resMem[i] = 1'((i / W) % 2);
        request();
        load(16'hA5C3, 1'b0);
        run_done(40);
        drain(1'b0);

        // Frame B: random data, random gaps, ready toggling 1,0,0,1
        for (int i = 0; i < W * H; i++) resMem[i] = 1'($urandom);
        rp = 16'($urandom);
        request();
        load(rp, 1'b1);
        run_done(10 + int'($urandom_range(0, 40)));
        drain(1'b1);

        // Frame C: engine never finishes -> watchdog
        rp = 16'($urandom);
        beats = 0;
        request();
        load(rp, 1'b1);
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            tick();
        end
        check("run_cycles_to_timeout", n, WD);
        check("timeout_pulse", {28'd0, timeoutErr, engReset, engStart, frameDone}, 32'b1100);
        tick();
        @(negedge clk);
        check("timeout_sticky", {30'd0, timeoutErr, engReset}, 32'b10);
        check("no_drain_on_timeout", beats, 0);
        tick();

        // Frame D: ack clears timeoutErr; reset mid-RUN aborts
        rp = 16'($urandom);
        request();
        load(rp, 1'b1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_mid_run");
        tick();

        // Frame E: recovery after abort
        for (int i = 0; i < W * H; i++) resMem[i] = 1'($urandom);
        rp = 16'($urandom);
        request();
        load(rp, 1'b1);
        run_done(10 + int'($urandom_range(0, 40)));
        drain(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
